// File: rtl/multicycle_alu_pkg.sv
// Shared definitions for the multicycle ALU: opcode encoding, FSM states and
// the shift-op classifier used by both the datapath and the control decoder.
package multicycle_alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_ANDN  = 4'b1010;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/multicycle_alu_comb_unit.sv
// Single-cycle ALU operations. Shift opcodes produce 0 here because shifting
// is iterated one bit per cycle by the enclosing block.
module alu_comb_unit
  import multicycle_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      ALU_ADD:   y_o = a_i + b_i;
      ALU_SUB:   y_o = a_i - b_i;
      ALU_AND:   y_o = a_i & b_i;
      ALU_OR:    y_o = a_i | b_i;
      ALU_XOR:   y_o = a_i ^ b_i;
      ALU_SLT:   y_o[0] = ($signed(a_i) < $signed(b_i));
      ALU_SLTU:  y_o[0] = (a_i < b_i);
      ALU_ANDN:  y_o = a_i & ~b_i;
      ALU_PASSB: y_o = b_i;
      default:   y_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU with a valid/ready handshake: single-cycle ops finish in one
// cycle, shifts iterate one bit per cycle in the result register itself.
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  state_e               state_q, state_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic [XLEN-1:0]      comb_y;

  alu_comb_unit #(.XLEN(XLEN)) u_comb (
    .op_i (alu_op),
    .a_i  (src_a),
    .b_i  (src_b),
    .y_o  (comb_y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= ALU_ADD;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end

  // result_q doubles as the shift working register, so DONE needs no extra copy.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    in_ready  = (state_q == ST_IDLE) && !flush;
    out_valid = (state_q == ST_DONE);

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_d = alu_op;
            if (is_shift_op(alu_op)) begin
              result_d = src_a;
              cnt_d    = src_b[SHAMT_W-1:0];
              state_d  = (src_b[SHAMT_W-1:0] == '0) ? ST_DONE : ST_SHIFT;
            end else begin
              result_d = comb_y;
              state_d  = ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          unique case (op_q)
            ALU_SLL: result_d = {result_q[XLEN-2:0], 1'b0};
            ALU_SRA: result_d = {result_q[XLEN-1], result_q[XLEN-1:1]};
            default: result_d = {1'b0, result_q[XLEN-1:1]};
          endcase
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == 1) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign zero   = (result_q == '0);

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: a latency/result model checked every
// cycle, plus hand-computed literal checks for each directed vector.
module tb_multicycle_alu;

  localparam int XLEN = 32;

  logic            clk, reset_n, in_valid, in_ready, flush;
  logic            out_valid, out_ready, zero;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] src_a, src_b, result;

  int total = 0;
  int bad   = 0;

  multicycle_alu #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] expectedResult(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return $unsigned($signed(a) >>> b[4:0]);
      4'd10:   return a & ~b;
      4'd15:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int expectedLatency(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'd7 || op == 4'd8 || op == 4'd9) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Model: a busy flag, a countdown to result-valid and the expected value.
  logic        mBusy = 1'b0;
  logic        mValid = 1'b0;
  int          mCount = 0;
  logic [31:0] mRes = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mBusy <= 1'b0; mValid <= 1'b0; mCount <= 0;
    end else if (flush) begin
      mBusy <= 1'b0; mValid <= 1'b0;
    end else if (!mBusy) begin
      if (in_valid) begin
        mBusy  <= 1'b1;
        mRes   <= expectedResult(alu_op, src_a, src_b);
        mCount <= expectedLatency(alu_op, src_b) - 1;
        mValid <= (expectedLatency(alu_op, src_b) == 1);
      end
    end else if (!mValid) begin
      mCount <= mCount - 1;
      if (mCount == 1) mValid <= 1'b1;
    end else if (out_ready) begin
      mBusy <= 1'b0; mValid <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      checkOutput("rst out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst zero", {31'd0, zero}, 32'd1);
      checkOutput("rst result", result, 32'd0);
    end else begin
      checkOutput("model in_ready", {31'd0, in_ready}, {31'd0, !mBusy && !flush});
      checkOutput("model out_valid", {31'd0, out_valid}, {31'd0, mValid});
      if (mValid) begin
        checkOutput("model result", result, mRes);
        checkOutput("model zero", {31'd0, zero}, {31'd0, mRes == 32'd0});
      end
    end
  end

  // Drives one request; it is accepted on the next edge and then the operand
  // buses are scrambled to show they are only sampled at accept.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; alu_op = op; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; alu_op = 4'($urandom); src_a = $urandom; src_b = $urandom;
  endtask

  task automatic waitResult(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!out_valid && cycles < 100);
    if (!out_valid) begin
      total++; bad++;
      $display("[TB] FAIL wait out_valid: got timeout after %0d cycles, expected valid", cycles);
    end
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int cyc;
    vecs.push_back('{"ADD wrap",  4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
    vecs.push_back('{"SUB",       4'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 1});
    vecs.push_back('{"AND",       4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1});
    vecs.push_back('{"OR",        4'd3,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1});
    vecs.push_back('{"XOR",       4'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1});
    vecs.push_back('{"SLT",       4'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
    vecs.push_back('{"SLTU",      4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
    vecs.push_back('{"SLL 0",     4'd7,  32'h80000000, 32'h00000000, 32'h80000000, 1});
    vecs.push_back('{"SRA 31",    4'd9,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 32});
    vecs.push_back('{"SRL 31",    4'd8,  32'h80000000, 32'h0000001F, 32'h00000001, 32});
    vecs.push_back('{"ANDN",      4'd10, 32'h0000F0F0, 32'h0000FF00, 32'h000000F0, 1});
    vecs.push_back('{"PASSB",     4'd15, 32'h00001234, 32'hCAFEBABE, 32'hCAFEBABE, 1});
    vecs.push_back('{"rsvd op",   4'd12, 32'h00000001, 32'h00000002, 32'h00000000, 1});
    vecs.push_back('{"SLL 4",     4'd7,  32'h00000001, 32'h00000024, 32'h00000010, 5});
    vecs.push_back('{"SRA pos 3", 4'd9,  32'h40000000, 32'h00000003, 32'h08000000, 4});

    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    alu_op = 4'd0; src_a = '0; src_b = '0;
    #22 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset in_ready", {31'd0, in_ready}, 32'd1);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitResult(cyc);
      checkOutput({vecs[i].name, " result"}, result, vecs[i].exp);
      checkOutput({vecs[i].name, " zero"}, {31'd0, zero}, {31'd0, vecs[i].exp == 32'd0});
      checkOutput({vecs[i].name, " latency"}, cyc, vecs[i].lat);
      releaseResult();
    end

    // Backpressure: result held for 5 extra cycles while a second request waits.
    applyStimulus(4'd0, 32'd3, 32'd4);
    waitResult(cyc);
    #1;
    in_valid = 1'b1; alu_op = 4'd0; src_a = 32'd100; src_b = 32'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("hold result", result, 32'd7);
      checkOutput("hold in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("hold out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    releaseResult();
    @(negedge clk);
    checkOutput("after release in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("after release out_valid", {31'd0, out_valid}, 32'd0);
    #1;

    // Flush three cycles into a 10-bit SLL, then an immediate new request.
    applyStimulus(4'd7, 32'h00000001, 32'd10);
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("flush out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush in_ready", {31'd0, in_ready}, 32'd1);
    #1;
    applyStimulus(4'd1, 32'd10, 32'd3);
    waitResult(cyc);
    checkOutput("post-flush result", result, 32'd7);
    checkOutput("post-flush latency", cyc, 1);
    releaseResult();

    // Asynchronous reset in the middle of an SRL.
    applyStimulus(4'd8, 32'hFFFF0000, 32'd20);
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("async rst out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async rst zero", {31'd0, zero}, 32'd1);
    checkOutput("async rst result", result, 32'd0);
    #12 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst release in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst release out_valid", {31'd0, out_valid}, 32'd0);
    #1;

    applyStimulus(4'd9, 32'h80000000, 32'd1);
    waitResult(cyc);
    checkOutput("final SRA 1", result, 32'hC0000000);
    checkOutput("final SRA 1 latency", cyc, 2);
    releaseResult();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
